seq_mult_32: RTL and testbench

Iterative 32×32→64 signed multiplier built around a 33-bit add/subtract step, one radix-2 Booth step per clock. It sits downstream of the ALU operand registers and upstream of the HI/LO register pair. It drives the add/sub datapath with per-step add/subtract selection and consumes the sums it produces.

---
 rtl/seq_mult_32.sv | 146 ++++++++++++++
 tb/tb_seq_mult_32.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_32.sv
// -----------------------------------------------------------------------------
// seq_mult_32
//   Iterative signed multiplier, DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH.
//   One radix-2 Booth step per clock through a (DATA_WIDTH+1)-bit add/sub.
//   A product takes DATA_WIDTH steps. The product is written to HI/LO on the
//   last step, and DONE pulses for one cycle in the cycle that follows.
//
// Ports
//   clk_i     system clock, rising edge
//   rst_ni    asynchronous active-low reset
//   start_i   start request, sampled only while idle
//   a_i       multiplicand, two's complement
//   b_i       multiplier, two's complement
//   hi_o      upper half of the last completed product
//   lo_o      lower half of the last completed product
//   busy_o    high while a multiply is in progress
//   done_o    one-cycle pulse; hi_o/lo_o valid from this cycle
// -----------------------------------------------------------------------------
module seq_mult_32 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [W:0]    m_q,   m_d;     // sign-extended multiplicand
  logic [W:0]    acc_q, acc_d;   // one guard bit, so -2^(W-1) can be subtracted safely
  logic [W-1:0]  q_q,   q_d;
  logic          q1_q,  q1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hi_q,  hi_d;
  logic [W-1:0]  lo_q,  lo_d;
  logic          done_q, done_d;

  // Booth step datapath
  logic [W:0]    addend;
  logic          carry_in;
  logic [W:0]    sum;
  logic [W:0]    acc_nx;
  logic [W-1:0]  q_nx;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    addend   = '0;
    carry_in = 1'b0;
    unique case ({q_q[0], q1_q})
      2'b01: addend = m_q;
      2'b10: begin
        addend   = ~m_q;        // subtract as ~M + 1
        carry_in = 1'b1;
      end
      default: ;
    endcase
    // Carry out of the top bit is dropped by the (W+1)-bit result width.
    sum    = acc_q + addend + (W+1)'(carry_in);
    // Arithmetic shift right of {ACC, Q, q_1}; the sign bit is replicated.
    acc_nx = {sum[W], sum[W:1]};
    q_nx   = {sum[0], q_q[W-1:1]};
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          m_d     = {a_i[W-1], a_i};
          acc_d   = '0;
          q_d     = b_i;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_nx;
        q_d   = q_nx;
        q1_d  = q_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          // Product is taken after the final shift.
          hi_d    = acc_nx[W-1:0];
          lo_d    = q_nx;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values of the previous cycle, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign done_o = done_q;
  assign busy_o = (state_q == RUN);

endmodule

// File: tb/tb_seq_mult_32.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_32
//   Self-checking bench for seq_mult_32. Fixed vectors come from a table;
//   random operand pairs are checked against a reference product computed
//   with plain 64-bit signed arithmetic. The multi-cycle corner cases
//   (START while busy, reset mid-operation, back-to-back) are written out
//   as separate sequences.
// -----------------------------------------------------------------------------
module tb_seq_mult_32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  seq_mult_32 #(.DATA_WIDTH(32)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .hi_o    (hi),
    .lo_o    (lo),
    .busy_o  (busy),
    .done_o  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: exact signed product.
  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  // One complete multiply with latency / pulse / busy checks.
  // Outputs are sampled on falling edges; n_j is the falling edge after
  // rising edge k+j, where k is the edge that samples START.
  task automatic run_mult(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp);
    int done_at;
    int done_cnt;
    int busy_cnt;
    logic [63:0] res;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);            // n_0
    start = 1'b0;
    a = $urandom; b = $urandom; // operand changes during RUN must not matter
    done_at = -1; done_cnt = 0; busy_cnt = busy ? 1 : 0;
    res = '0;
    for (int j = 1; j <= 34; j++) begin
      @(negedge clk);
      if (j <= 31 && busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = j;
          res = {hi, lo};
        end
      end
    end
    check({name, " product"}, res, exp);
    check({name, " done latency"}, 64'(done_at), 64'd32);
    check({name, " done pulses"}, 64'(done_cnt), 64'd1);
    check({name, " busy cycles"}, 64'(busy_cnt), 64'd32);
    check({name, " idle after"}, {63'd0, busy}, 64'd0);
    check({name, " hold"}, {hi, lo}, exp);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'd10,       32'd20,       32'h00000000, 32'h000000C8};
    vecs[1] = '{32'hFFFFFFF6, 32'd20,       32'hFFFFFFFF, 32'hFFFFFF38};
    vecs[2] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[3] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[5] = '{32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
    vecs[6] = '{32'hDEADBEEF, 32'h00000000, 32'h00000000, 32'h00000000};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset state", {29'd0, busy, done, 1'b0, hi, lo} , 64'd0);
    rst_n = 1'b1;

    // ---------------- table vectors ----------------
    for (int i = 0; i < 7; i++)
      run_mult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, {vecs[i].exp_hi, vecs[i].exp_lo});

    // ---------------- random vs model ----------------
    for (int i = 0; i < 8; i++) begin
      logic [31:0] x;
      logic [31:0] y;
      x = $urandom; y = $urandom;
      if (i == 0) x = 32'h80000000;
      if (i == 1) y = 32'hFFFFFFFF;
      run_mult($sformatf("rand%0d", i), x, y, ref_prod(x, y));
    end

    // ---------------- START while busy ----------------
    begin
      int done_cnt;
      @(negedge clk);
      a = 32'd3; b = 32'd5; start = 1'b1;
      @(negedge clk);          // n_0
      start = 1'b0;
      done_cnt = 0;
      for (int j = 1; j <= 66; j++) begin
        @(negedge clk);
        if (j == 9) begin
          a = 32'd7; b = 32'd9; start = 1'b1;
        end
        if (j == 33) start = 1'b0;
        if (done) done_cnt++;
        if (j == 32) begin
          check("busy-start first product", {hi, lo}, 64'd15);
          check("busy-start done at 32", {63'd0, done}, 64'd1);
          check("busy-start idle at 32", {63'd0, busy}, 64'd0);
        end
        if (j == 33) check("busy-start held start accepted", {63'd0, busy}, 64'd1);
        if (j == 64) check("busy-start held product kept", {hi, lo}, 64'd15);
        if (j == 65) begin
          check("busy-start second product", {hi, lo}, 64'd63);
          check("busy-start second done", {63'd0, done}, 64'd1);
        end
      end
      check("busy-start done pulses", 64'(done_cnt), 64'd2);
    end

    // ---------------- reset mid-operation ----------------
    run_mult("pre-reset", 32'd6, 32'd7, 64'd42);
    begin
      int done_cnt;
      @(negedge clk);
      a = 32'd100; b = 32'd200; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid-reset outputs", {29'd0, busy, done, 1'b0, hi, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      for (int j = 0; j < 40; j++) begin
        @(negedge clk);
        if (done) done_cnt++;
      end
      check("mid-reset no done", 64'(done_cnt), 64'd0);
      check("mid-reset stays zero", {hi, lo}, 64'd0);
    end
    run_mult("post-reset", 32'd6, 32'd7, 64'd42);

    // ---------------- back-to-back ----------------
    begin
      logic [31:0] xs[$];
      logic [31:0] ys[$];
      int idx;
      int since;
      int cyc;
      for (int i = 0; i < 20; i++) begin
        xs.push_back($urandom);
        ys.push_back($urandom);
      end
      @(negedge clk);
      a = xs[0]; b = ys[0]; start = 1'b1;
      idx = 0; since = 0; cyc = 0;
      while (idx < 20 && cyc < 20 * 33 + 100) begin
        @(negedge clk);
        cyc++;
        since++;
        start = 1'b0;
        if (done) begin
          check($sformatf("b2b%0d product", idx), {hi, lo}, ref_prod(xs[idx], ys[idx]));
          if (idx > 0) check($sformatf("b2b%0d spacing", idx), 64'(since), 64'd33);
          since = 0;
          idx++;
          if (idx < 20) begin
            a = xs[idx]; b = ys[idx]; start = 1'b1;
          end
        end
      end
      check("b2b all completed", 64'(idx), 64'd20);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
